ball_motion_controller: RTL
===========================

// Module: ball_motion_controller
// PURPOSE
//   Per-frame sequencer for the pong ball. On each frame tick it advances the ball by a
//   fixed step, bounces it off the playfield border and the paddle, and detects misses.
//   It sequences the serve/play/miss cycle and presents ball_x/ball_y to the pixel-side
//   ball renderer. Runs in the pixel clock domain; frame_tick comes from the vsync edge detector.
// PARAMETERS
//   POSITION_REG_MAX   11    MSB index of all position buses (12-bit unsigned)
//   GRAPHICS_WIDTH     1280  active width, pixels
//   GRAPHICS_HEIGHT    800   active height, pixels
//   BORDER_WIDTH       50    border thickness, pixels
//   BALL_RADIUS        10    ball radius, pixels
//   BALL_SPEED         4     per-axis step per frame, pixels
//   BALL_START_X       640   serve position x
//   BALL_START_Y       400   serve position y
//   PADDLE_WIDTH       20    paddle x extent
//   PADDLE_LENGTH      200   paddle y extent
//   SERVE_DELAY_FRAMES 60    frame ticks held in SERVE before launch (>=1)
// PORTS
//   pixel_clock  in   1   sole clock; all state updates on its rising edge
//   reset        in   1   synchronous, active-high
//   frame_tick   in   1   one-cycle pulse, once per frame
//   pause        in   1   high: frame_tick ignored, all state held
//   paddle_x     in   12  paddle left edge
//   paddle_y     in   12  paddle top edge
//   ball_x       out  12  ball centre x
//   ball_y       out  12  ball centre y
//   state        out  2   0=SERVE 1=MOVE 2=MISS
//   paddle_hit   out  1   one-cycle pulse on paddle bounce
//   miss         out  1   one-cycle pulse on MOVE->MISS
//   miss_count   out  4   misses since reset, saturates at 15
// BEHAVIOUR
//   - Reset: state=SERVE, ball=(BALL_START_X,BALL_START_Y), dir_x=left, dir_y=down,
//     serve counter=0, miss_count=0, paddle_hit=0, miss=0. Reset beats a coincident frame_tick.
//   - "Tick" = frame_tick & ~pause. All updates land the cycle after the tick (latency 1);
//     pulses are high for exactly that one cycle. Nothing changes between ticks.
//   - SERVE: ball held at start. Each tick increments the counter; on the tick bringing it to
//     SERVE_DELAY_FRAMES -> MOVE, counter cleared, dir_x=left, dir_y toggles (alternating serves).
//   - MOVE, per tick, x and y evaluated independently, same cycle; bound comparisons use
//     13-bit intermediates (no wrap):
//     * up:    ball_y < BORDER_WIDTH+BALL_RADIUS+BALL_SPEED -> ball_y=BORDER_WIDTH+BALL_RADIUS, dir_y=down;
//              else ball_y -= BALL_SPEED
//     * down:  ball_y+BALL_RADIUS+BALL_SPEED > GRAPHICS_HEIGHT-BORDER_WIDTH -> clamp to
//              GRAPHICS_HEIGHT-BORDER_WIDTH-BALL_RADIUS, dir_y=up; else ball_y += BALL_SPEED
//     * right: same rule against GRAPHICS_WIDTH-BORDER_WIDTH, clamp, dir_x=left
//     * left, paddle: face=paddle_x+PADDLE_WIDTH; if ball_x-BALL_RADIUS >= face and
//       ball_x-BALL_RADIUS-BALL_SPEED <= face and paddle_y <= ball_y <= paddle_y+PADDLE_LENGTH
//       (inclusive) -> ball_x=face+BALL_RADIUS, dir_x=right, paddle_hit=1
//     * left, miss (no paddle hit): ball_x < BORDER_WIDTH+BALL_RADIUS+BALL_SPEED -> state=MISS,
//       miss=1, miss_count+1 (held at 15); ball x AND y frozen this tick
//     * otherwise ball_x -= BALL_SPEED
//     * corner case: x and y bounces on the same tick both apply. Paddle hit beats miss.
//   - MISS: next tick -> SERVE, ball reset to start, counter=0.
//   - pause high mid-MOVE: position, direction, counter, state all frozen; resumes unchanged.
//   - reset in any state returns to reset values on the next edge; miss_count cleared.
// TESTING
//   1 reset, 60 ticks -> state=MOVE after 60th tick; ball still (640,400); next tick -> (636,404)
//   2 MOVE, ball (700,744) moving down/right, tick -> ball_y=740, dir_y=up, ball_x=704
//   3 paddle (110,300), ball (144,400) moving left, tick -> ball_x=140, paddle_hit 1 cycle, dir_x=right
//   4 paddle_y=600, ball (63,400) moving left, tick -> state=MISS, miss 1 cycle, miss_count=1,
//     ball frozen; next tick -> SERVE at (640,400); 16 misses -> miss_count stays 15
//   5 pause=1 with 10 frame_ticks in MOVE -> no output change; pause=0, tick -> single step
//   6 reset asserted coincident with frame_tick in MOVE -> SERVE, (640,400), no pulses

Source files
------------

// File: rtl/ball_motion_controller.sv
// rtl/ball_motion_controller.sv - per-frame pong ball sequencer: serve/move/miss, wall and paddle bounces
module ball_motion_controller #(
  parameter int POSITION_REG_MAX   = 11,
  parameter int GRAPHICS_WIDTH     = 1280,
  parameter int GRAPHICS_HEIGHT    = 800,
  parameter int BORDER_WIDTH       = 50,
  parameter int BALL_RADIUS        = 10,
  parameter int BALL_SPEED         = 4,
  parameter int BALL_START_X       = 640,
  parameter int BALL_START_Y       = 400,
  parameter int PADDLE_WIDTH       = 20,
  parameter int PADDLE_LENGTH      = 200,
  parameter int SERVE_DELAY_FRAMES = 60
) (
  input  logic                      i_pixel_clock,
  input  logic                      i_reset,
  input  logic                      i_frame_tick,
  input  logic                      i_pause,
  input  logic [POSITION_REG_MAX:0] i_paddle_x,
  input  logic [POSITION_REG_MAX:0] i_paddle_y,
  output logic [POSITION_REG_MAX:0] o_ball_x,
  output logic [POSITION_REG_MAX:0] o_ball_y,
  output logic [1:0]                o_state,
  output logic                      o_paddle_hit,
  output logic                      o_miss,
  output logic [3:0]                o_miss_count
);

  localparam int PW = POSITION_REG_MAX + 1;
  localparam int CW = $clog2(SERVE_DELAY_FRAMES + 1);

  typedef logic [PW-1:0] pos_t;
  typedef logic [PW:0]   ext_t;
  typedef enum logic [1:0] {ST_SERVE = 2'd0, ST_MOVE = 2'd1, ST_MISS = 2'd2} state_t;

  // Bound comparisons carry one extra bit so sums near the top of the range never wrap
  localparam ext_t C_R      = ext_t'(BALL_RADIUS);
  localparam ext_t C_RS     = ext_t'(BALL_RADIUS + BALL_SPEED);
  localparam ext_t C_LO_LIM = ext_t'(BORDER_WIDTH + BALL_RADIUS + BALL_SPEED);
  localparam ext_t C_Y_HI   = ext_t'(GRAPHICS_HEIGHT - BORDER_WIDTH);
  localparam ext_t C_X_HI   = ext_t'(GRAPHICS_WIDTH - BORDER_WIDTH);
  localparam ext_t C_PW     = ext_t'(PADDLE_WIDTH);
  localparam ext_t C_PL     = ext_t'(PADDLE_LENGTH);

  localparam pos_t P_SPEED    = pos_t'(BALL_SPEED);
  localparam pos_t P_START_X  = pos_t'(BALL_START_X);
  localparam pos_t P_START_Y  = pos_t'(BALL_START_Y);
  localparam pos_t P_LO_CLAMP = pos_t'(BORDER_WIDTH + BALL_RADIUS);
  localparam pos_t P_Y_CLAMP  = pos_t'(GRAPHICS_HEIGHT - BORDER_WIDTH - BALL_RADIUS);
  localparam pos_t P_X_CLAMP  = pos_t'(GRAPHICS_WIDTH - BORDER_WIDTH - BALL_RADIUS);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(SERVE_DELAY_FRAMES - 1);

  state_t        r_state, w_state_next;
  pos_t          r_ball_x, w_ball_x_next;
  pos_t          r_ball_y, w_ball_y_next;
  logic          r_dir_right, w_dir_right_next;
  logic          r_dir_down, w_dir_down_next;
  logic          r_serve_down, w_serve_down_next;
  logic [CW-1:0] r_serve_cnt, w_serve_cnt_next;
  logic [3:0]    r_miss_count, w_miss_count_next;
  logic          r_paddle_hit, w_paddle_hit_next;
  logic          r_miss, w_miss_next;

  logic w_tick;
  ext_t w_bx, w_by, w_face, w_face_r;
  logic w_y_lo_hit, w_y_hi_hit, w_x_hi_hit, w_x_lo_hit, w_on_paddle;

  assign w_tick     = i_frame_tick & ~i_pause;
  assign w_bx       = {1'b0, r_ball_x};
  assign w_by       = {1'b0, r_ball_y};
  assign w_face     = {1'b0, i_paddle_x} + C_PW;
  assign w_face_r   = w_face + C_R;
  assign w_y_lo_hit = w_by < C_LO_LIM;
  assign w_y_hi_hit = (w_by + C_RS) > C_Y_HI;
  assign w_x_hi_hit = (w_bx + C_RS) > C_X_HI;
  assign w_x_lo_hit = w_bx < C_LO_LIM;
  assign w_on_paddle = (w_bx >= w_face_r) && (w_bx <= w_face + C_RS) &&
                       (i_paddle_y <= r_ball_y) && (w_by <= {1'b0, i_paddle_y} + C_PL);

  always_comb begin
    w_state_next      = r_state;
    w_ball_x_next     = r_ball_x;
    w_ball_y_next     = r_ball_y;
    w_dir_right_next  = r_dir_right;
    w_dir_down_next   = r_dir_down;
    w_serve_down_next = r_serve_down;
    w_serve_cnt_next  = r_serve_cnt;
    w_miss_count_next = r_miss_count;
    w_paddle_hit_next = 1'b0;
    w_miss_next       = 1'b0;
    if (w_tick) begin
      case (r_state)
        ST_SERVE: begin
          if (r_serve_cnt == C_CNT_LAST) begin
            // Serves alternate vertically, the first one after reset heading down
            w_state_next      = ST_MOVE;
            w_serve_cnt_next  = '0;
            w_dir_right_next  = 1'b0;
            w_dir_down_next   = r_serve_down;
            w_serve_down_next = ~r_serve_down;
          end else begin
            w_serve_cnt_next = r_serve_cnt + CW'(1);
          end
        end
        ST_MOVE: begin
          if (!r_dir_down) begin
            if (w_y_lo_hit) begin
              w_ball_y_next   = P_LO_CLAMP;
              w_dir_down_next = 1'b1;
            end else begin
              w_ball_y_next = r_ball_y - P_SPEED;
            end
          end else if (w_y_hi_hit) begin
            w_ball_y_next   = P_Y_CLAMP;
            w_dir_down_next = 1'b0;
          end else begin
            w_ball_y_next = r_ball_y + P_SPEED;
          end

          if (r_dir_right) begin
            if (w_x_hi_hit) begin
              w_ball_x_next    = P_X_CLAMP;
              w_dir_right_next = 1'b0;
            end else begin
              w_ball_x_next = r_ball_x + P_SPEED;
            end
          end else if (w_on_paddle) begin
            w_ball_x_next     = w_face_r[PW-1:0];
            w_dir_right_next  = 1'b1;
            w_paddle_hit_next = 1'b1;
          end else if (w_x_lo_hit) begin
            // A miss freezes the whole ball, including any vertical bounce this tick
            w_state_next      = ST_MISS;
            w_miss_next       = 1'b1;
            w_ball_y_next     = r_ball_y;
            w_dir_down_next   = r_dir_down;
            w_miss_count_next = (r_miss_count == 4'hF) ? r_miss_count : r_miss_count + 4'd1;
          end else begin
            w_ball_x_next = r_ball_x - P_SPEED;
          end
        end
        ST_MISS: begin
          w_state_next     = ST_SERVE;
          w_ball_x_next    = P_START_X;
          w_ball_y_next    = P_START_Y;
          w_serve_cnt_next = '0;
        end
        default: w_state_next = ST_SERVE;
      endcase
    end
  end

  always_ff @(posedge i_pixel_clock) begin
    if (i_reset) begin
      r_state      <= ST_SERVE;
      r_ball_x     <= P_START_X;
      r_ball_y     <= P_START_Y;
      r_dir_right  <= 1'b0;
      r_dir_down   <= 1'b1;
      r_serve_down <= 1'b1;
      r_serve_cnt  <= '0;
      r_miss_count <= '0;
      r_paddle_hit <= 1'b0;
      r_miss       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_ball_x     <= w_ball_x_next;
      r_ball_y     <= w_ball_y_next;
      r_dir_right  <= w_dir_right_next;
      r_dir_down   <= w_dir_down_next;
      r_serve_down <= w_serve_down_next;
      r_serve_cnt  <= w_serve_cnt_next;
      r_miss_count <= w_miss_count_next;
      r_paddle_hit <= w_paddle_hit_next;
      r_miss       <= w_miss_next;
    end
  end

  assign o_ball_x     = r_ball_x;
  assign o_ball_y     = r_ball_y;
  assign o_state      = r_state;
  assign o_paddle_hit = r_paddle_hit;
  assign o_miss       = r_miss;
  assign o_miss_count = r_miss_count;

endmodule
